// File: rtl/ex_result_queue.sv
// In-order completion queue between the EX units and writeback: compacting multi-lane enqueue,
// multi-lane in-order dequeue. Define EX_RESULT_QUEUE_BYPASS_EN for same-cycle empty-queue bypass.
module ex_result_queue #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned NUM_OUT = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*DATA_W-1:0]     in_data,
  output logic                         in_ready,
  output logic [NUM_OUT-1:0]           out_valid,
  output logic [NUM_OUT*DATA_W-1:0]    out_data,
  input  logic [NUM_OUT-1:0]           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CmpN = (NUM_IN > NUM_OUT) ? NUM_IN : NUM_OUT;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IdxW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  int unsigned       rank [NUM_IN];
  logic [DATA_W-1:0] cmp_data [CmpN];
  int unsigned       n_in, n_pop, n_skip;
  logic              bypass;
  logic [NUM_IN-1:0] wr_en;
  logic [IdxW-1:0]   wr_idx [NUM_IN];

  // Index arithmetic for any DEPTH; callers keep base + off below 2*DEPTH.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return sum[IdxW-1:0];
  endfunction

  assign in_ready = (32'(count_q) <= DEPTH - NUM_IN);
  assign count    = count_q;
  assign overflow = overflow_q;

  // Compact valid lanes into consecutive slots, lowest lane first.
  always_comb begin
    n_in = 0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      rank[i] = n_in;
      if (in_valid[i]) n_in = n_in + 1;
    end
    for (int unsigned k = 0; k < CmpN; k++) begin
      cmp_data[k] = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (in_valid[i] && rank[i] == k) cmp_data[k] = in_data[i*DATA_W +: DATA_W];
      end
    end
`ifdef EX_RESULT_QUEUE_BYPASS_EN
    bypass = (count_q == '0) && in_ready && !flush;
`else
    bypass = 1'b0;
`endif
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int unsigned j = 0; j < NUM_OUT; j++) begin
      if (32'(count_q) > j) begin
        out_valid[j]                  = 1'b1;
        out_data[j*DATA_W +: DATA_W]  = mem_q[wrap_add(head_q, j)];
      end
    end
`ifdef EX_RESULT_QUEUE_BYPASS_EN
    if (bypass) begin
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
        if (j < n_in) begin
          out_valid[j]                 = 1'b1;
          out_data[j*DATA_W +: DATA_W] = cmp_data[j];
        end
      end
    end
`endif
    // Only a contiguous run of accepted lanes from lane 0 pops.
    n_pop = 0;
    for (int unsigned j = 0; j < NUM_OUT; j++) begin
      if (n_pop == j && out_valid[j] && out_ready[j]) n_pop = n_pop + 1;
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en      = '0;
    n_skip     = bypass ? n_pop : 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      wr_idx[k] = (k >= n_skip) ? wrap_add(tail_q, k - n_skip) : '0;
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (|in_valid) begin
        if (in_ready) begin
          for (int unsigned k = 0; k < NUM_IN; k++) begin
            wr_en[k] = (k < n_in) && (k >= n_skip);
          end
          tail_d = wrap_add(tail_q, n_in - n_skip);
        end else begin
          overflow_d = 1'b1;
        end
      end
      // Bypassed pops come straight from the inputs and never touch storage.
      if (!bypass) head_d = wrap_add(head_q, n_pop);
      count_d = CntW'(32'(count_q) + (in_ready ? n_in : 0) - n_skip - (bypass ? 0 : n_pop));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (wr_en[k]) mem_q[wr_idx[k]] <= cmp_data[k];
    end
  end

endmodule

// File: tb/tb_ex_result_queue.sv
// Directed bench for ex_result_queue: default instance (DEPTH=8) plus a DEPTH=5 wrap instance.
module tb_ex_result_queue;

  localparam int W = 64;
  localparam logic [63:0] PA = 64'hAAAA_0000_0000_0001, PB = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] PC = 64'hCCCC_0000_0000_0003, PD = 64'hDDDD_0000_0000_0004;
  localparam logic [63:0] PE = 64'hEEEE_0000_0000_0005, PF = 64'hFFFF_0000_0000_0006;
  localparam logic [63:0] PG = 64'h1111_0000_0000_0007, PH = 64'h2222_0000_0000_0008;
  localparam logic [63:0] PI = 64'h3333_0000_0000_0009, PJ = 64'h4444_0000_0000_000A;
  localparam logic [63:0] PK = 64'h5555_0000_0000_000B, PL = 64'h6666_0000_0000_000C;
  localparam logic [63:0] PM = 64'h7777_0000_0000_000D, PN = 64'h8888_0000_0000_000E;
  localparam logic [63:0] PP = 64'h9999_0000_0000_0010, PQ = 64'h9999_0000_0000_0011;
  localparam logic [63:0] PR = 64'h9999_0000_0000_0012, PS = 64'h9999_0000_0000_0013;
  localparam logic [63:0] PX = 64'h5A5A_0000_0000_0020, PY = 64'h5A5A_0000_0000_0021;
  localparam logic [63:0] PZ = 64'h5A5A_0000_0000_0022, Z64 = 64'h0;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         flush, in_ready, overflow;
  logic [2:0]   in_valid;
  logic [191:0] in_data;
  logic [1:0]   out_valid, out_ready;
  logic [127:0] out_data;
  logic [3:0]   count;

  logic         b_flush, b_in_ready, b_overflow;
  logic [2:0]   b_in_valid;
  logic [191:0] b_in_data;
  logic [1:0]   b_out_valid, b_out_ready;
  logic [127:0] b_out_data;
  logic [2:0]   b_count;

  int checks = 0;
  int errors = 0;

  ex_result_queue #(.DATA_W(64), .DEPTH(8), .NUM_IN(3), .NUM_OUT(2)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .overflow(overflow)
  );

  ex_result_queue #(.DATA_W(64), .DEPTH(5), .NUM_IN(3), .NUM_OUT(2)) dut5 (
    .clock(clock), .reset(reset), .flush(b_flush), .in_valid(b_in_valid),
    .in_data(b_in_data), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_ready(b_out_ready), .count(b_count), .overflow(b_overflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    flush = 0; in_valid = '0; in_data = '0; out_ready = '0;
    b_flush = 0; b_in_valid = '0; b_in_data = '0; b_out_ready = '0;
    reset = 0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_b_count", b_count, 0);
    reset = 1;
    tick();

    // Compaction: lanes 0 and 2 valid, lane 1 carries junk.
    in_valid = 3'b101; in_data = {PC, PB, PA};
    tick(); in_valid = '0; in_data = '0;
    chk("cmp_count", count, 2);
    chk("cmp_out_valid", out_valid, 2'b11);
    chk("cmp_out_data", out_data, {PC, PA});

    in_valid = 3'b010; in_data = {Z64, PD, Z64};
    tick(); in_valid = '0;
    chk("enq_d_count", count, 3);

    out_ready = 2'b10;
    tick();
    chk("nopop_count", count, 3);
    chk("nopop_data", out_data, {PC, PA});
    out_ready = 2'b11;
    tick(); out_ready = '0;
    chk("pop2_count", count, 1);
    chk("pop2_valid", out_valid, 2'b01);
    chk("pop2_data", out_data, {Z64, PD});

    // Fill to 6, then a dropped write.
    in_valid = 3'b111; in_data = {PG, PF, PE};
    tick();
    chk("fill4_count", count, 4);
    chk("fill4_ready", in_ready, 1);
    in_valid = 3'b011; in_data = {Z64, PI, PH};
    tick();
    chk("fill6_count", count, 6);
    chk("fill6_ready", in_ready, 0);
    chk("fill6_ovf", overflow, 0);
    in_valid = 3'b001; in_data = {Z64, Z64, PK};
    tick(); in_valid = '0;
    chk("drop_count", count, 6);
    chk("drop_ovf", overflow, 1);
    chk("drop_data", out_data, {PE, PD});
    out_ready = 2'b01;
    tick(); out_ready = '0;
    chk("pop1_count", count, 5);
    chk("pop1_ready", in_ready, 1);
    chk("pop1_ovf", overflow, 1);
    chk("pop1_data", out_data, {PF, PE});
    out_ready = 2'b01;
    tick(); out_ready = '0;
    chk("pop1b_data", out_data, {PG, PF});

    // Flush with same-cycle inputs and pops.
    flush = 1; in_valid = 3'b111; in_data = {PM, PL, PK}; out_ready = 2'b11;
    #1;
    chk("flush_cycle_valid", out_valid, 2'b11);
    tick(); flush = 0; in_valid = '0; in_data = '0; out_ready = '0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_data", out_data, 0);
    chk("flush_ovf", overflow, 1);
    chk("flush_ready", in_ready, 1);

    in_valid = 3'b010; in_data = {Z64, PJ, Z64};
    tick(); in_valid = '0;
    chk("postflush_count", count, 1);
    chk("postflush_data", out_data, {Z64, PJ});

    // Enqueue and dequeue in the same cycle.
    in_valid = 3'b011; in_data = {Z64, PL, PK}; out_ready = 2'b11;
    tick(); in_valid = '0; out_ready = '0;
    chk("simul_count", count, 2);
    chk("simul_data", out_data, {PL, PK});
    out_ready = 2'b11;
    tick(); out_ready = '0;
    chk("drain_count", count, 0);

    in_valid = 3'b011; in_data = {Z64, PN, PM}; out_ready = 2'b01;
    #1;
`ifdef EX_RESULT_QUEUE_BYPASS_EN
    chk("byp_valid", out_valid, 2'b11);
    chk("byp_data", out_data, {PN, PM});
    tick(); in_valid = '0; out_ready = '0;
    chk("byp_count", count, 1);
    chk("byp_stored", out_data, {Z64, PN});
`else
    chk("nobyp_valid", out_valid, 2'b00);
    chk("nobyp_data", out_data, 0);
    tick(); in_valid = '0; out_ready = '0;
    chk("nobyp_count", count, 2);
    chk("nobyp_stored", out_data, {PN, PM});
`endif

    // DEPTH=5 wrap-around.
    b_in_valid = 3'b111; b_in_data = {PR, PQ, PP};
    tick(); b_in_valid = '0;
    chk("w_count3", b_count, 3);
    chk("w_ready3", b_in_ready, 0);
    b_out_ready = 2'b11;
    tick(); b_out_ready = '0;
    chk("w_count1", b_count, 1);
    chk("w_data1", b_out_data, {Z64, PR});
    chk("w_ready1", b_in_ready, 1);
    b_in_valid = 3'b100; b_in_data = {PS, Z64, Z64};
    tick(); b_in_valid = '0;
    chk("w_count2", b_count, 2);
    b_in_valid = 3'b111; b_in_data = {PZ, PY, PX};
    tick(); b_in_valid = '0;
    chk("w_count5", b_count, 5);
    chk("w_data5", b_out_data, {PS, PR});
    b_out_ready = 2'b11;
    tick();
    chk("w_xy", b_out_data, {PY, PX});
    chk("w_count_xy", b_count, 3);
    tick();
    chk("w_z", b_out_data, {Z64, PZ});
    chk("w_z_valid", b_out_valid, 2'b01);
    tick(); b_out_ready = '0;
    chk("w_empty", b_count, 0);
    chk("w_ovf", b_overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_result_queue.md
Name: ex_result_queue

Overview:
- Parametrised in-order completion queue between the EX functional units and the complete/writeback stage.
- Accepts up to NUM_IN result packets per cycle on explicit valid lanes and stores them in a circular buffer of DEPTH entries.
- Presents up to NUM_OUT oldest entries per cycle under a valid/ready handshake.
- Supports flush on branch mispredict and drives a registered-count in_ready for upstream stall.

Parameters:
DATA_W, 64, width of one result packet (flattened EX packet)
DEPTH, 8, number of storage entries; any integer >= max(NUM_IN, NUM_OUT), need not be a power of 2
NUM_IN, 3, number of input lanes (FU result ports)
NUM_OUT, 2, number of output lanes (complete ports)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
flush  input  1  synchronous clear of queue and same-cycle inputs
in_valid  input  NUM_IN  per-lane packet valid
in_data  input  NUM_IN*DATA_W  per-lane packets; lane i at bits [i*DATA_W +: DATA_W]
in_ready  output  1  queue can absorb NUM_IN packets this cycle
out_valid  output  NUM_OUT  per-lane output valid; lane 0 is oldest
out_data  output  NUM_OUT*DATA_W  oldest entries in age order
out_ready  input  NUM_OUT  per-lane consumer ready
count  output  $clog2(DEPTH+1)  registered occupancy
overflow  output  1  sticky; set when a valid input was dropped

Behaviour:
- Reset (reset==0 at a clock edge):
  - head=0, tail=0, count=0, overflow=0.
  - Storage contents are don't-care; out_valid=0.
  - Reset overrides flush and all inputs.
- in_ready:
  - Asserted when count <= DEPTH-NUM_IN.
  - Depends only on registered count; never on same-cycle pops.
- Enqueue:
  - When in_ready=1, every lane with in_valid=1 is written.
  - Lanes are compacted in ascending lane index: lowest valid lane goes to tail, next to tail+1, and so on.
  - Invalid lanes create no holes.
  - tail advances by popcount(in_valid), modulo DEPTH.
- Dropped input:
  - in_valid!=0 while in_ready=0 writes nothing and sets overflow.
  - overflow stays set until reset.
- Output presentation:
  - out_valid[j]=1 iff j < count (without bypass).
  - out_data lane j = entry (head+j) mod DEPTH.
  - out_valid is never set for empty slots.
  - out_data for invalid lanes is all zeros.
- Dequeue:
  - Pop count P = number of leading lanes j (from 0) with out_valid[j] & out_ready[j].
  - A lane pops only if all lower lanes pop, which keeps ordering strict.
  - head advances by P modulo DEPTH.
- Count update: count_next = count + enq - P.
- Simultaneous enqueue and dequeue are legal in the same cycle; enqueue slots are computed from the current tail.
- Wrap-around:
  - All index arithmetic is modulo DEPTH, including non-power-of-2 DEPTH.
  - A multi-lane write straddling entry DEPTH-1 continues at entry 0.
- Flush:
  - If flush=1 at an edge (reset deasserted): head=0, tail=0, count=0.
  - Same-cycle inputs are discarded and same-cycle pops are ignored.
  - overflow is unchanged.
  - out_valid still reflects pre-flush state during the flush cycle; the consumer must qualify with flush.
- Latency: an enqueued packet is visible on out_* the cycle after acceptance (see optional feature).

Optional Feature:
- Macro: EX_RESULT_QUEUE_BYPASS_EN.
- Enabled:
  - When count==0 and in_ready=1, the compacted valid inputs drive out_valid/out_data combinationally in the same cycle, lane order preserved.
  - Inputs popped by out_ready that cycle are not stored; only the unpopped remainder is written starting at tail.
  - When count!=0, there is no bypass; behaviour matches the disabled case.
  - flush=1 suppresses bypass valids.
- Disabled:
  - Outputs are driven only from storage.
  - Minimum latency is 1 cycle; no combinational path from in_* to out_*.

Test Plan:
- Reset sequence: hold reset=0 for 2 cycles, release -> count=0, out_valid=0, in_ready=1, overflow=0.
- Compacting enqueue (defaults): in_valid=3'b101 with A on lane 0 and C on lane 2, out_ready=0.
  - Bypass off -> next cycle count=2, out_data lane 0=A, lane 1=C, out_valid=2'b11.
- Ordered pop: queue holds A,B,C with out_ready=2'b10 -> P=0, count stays 3.
  - Then out_ready=2'b11 -> A and B popped, next cycle lane 0=C, count=1.
- Full / overflow: fill to count=6 (in_ready=0 since 6 > 8-3), drive in_valid=3'b001 -> nothing written, overflow=1.
  - Then pop 1 -> count=5, in_ready=1.
- Wrap with DEPTH=5, NUM_IN=3: advance tail to 4, enqueue X,Y,Z -> entries 4,0,1 hold X,Y,Z.
  - Draining returns X,Y,Z in order.
- Flush mid-traffic: count=4, assert flush with in_valid=3'b111 and out_ready=2'b11 -> next cycle count=0, out_valid=0, overflow unchanged.
  - With EX_RESULT_QUEUE_BYPASS_EN: empty queue, in_valid=3'b011 with out_ready=2'b01 -> lane 0 output same cycle, next cycle count=1 holding the lane-1 packet.
